// File: rtl/gcd_mmio_port.sv
// Memory-mapped port that hands GCD jobs from an external requester to rv32i firmware.
// Firmware claims a latched job, computes it, and stores the result; the port then holds it and raises calc_done.
module gcd_mmio_port #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calc_start,
    input  logic [31:0] gcd_a,
    input  logic [31:0] gcd_b,
    output logic [31:0] gcd_result,
    output logic        calc_done,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        mem_hit
);

    // One-hot encoding doubles as the STATUS register value.
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        PENDING = 3'b001,
        BUSY    = 3'b010,
        DONE    = 3'b100
    } state_t;

    state_t             state;
    logic               start_q;
    logic [31:0]        opa;
    logic [31:0]        opb;
    logic [CNT_W-1:0]   cycles;
    logic [31:0]        cycles_rd;
    logic [3:0]         offset;
    logic               req;
    logic               wr;
    logic               claim_wr;
    logic               result_wr;
    logic [1:0]         unused_addr;

    assign req         = calc_start & ~start_q;
    assign mem_hit     = (mem_addr[31:6] == BASE_ADDR[31:6]);
    assign offset      = mem_addr[5:2];
    assign unused_addr = mem_addr[1:0];
    assign wr          = mem_we & mem_hit;
    assign claim_wr    = wr & (offset == 4'h4) & mem_wdata[0];
    assign result_wr   = wr & (offset == 4'h3);
    assign cycles_rd   = 32'(cycles);

    always_comb begin
        mem_rdata = '0;
        if (mem_re && mem_hit) begin
            case (offset)
                4'h0:    mem_rdata = {29'b0, state};
                4'h1:    mem_rdata = opa;
                4'h2:    mem_rdata = opb;
                4'h5:    mem_rdata = cycles_rd;
                default: mem_rdata = '0;
            endcase
        end
    end

    // Requests outside IDLE/DONE are dropped; a RESULT store beats a same-cycle request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            cycles     <= '0;
            gcd_result <= '0;
            calc_done  <= 1'b0;
        end else begin
            start_q <= calc_start;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= PENDING;
                        opa   <= gcd_a;
                        opb   <= gcd_b;
                    end
                end
                PENDING: begin
                    if (claim_wr) begin
                        state  <= BUSY;
                        cycles <= '0;
                    end
                end
                BUSY: begin
                    if (cycles != {CNT_W{1'b1}}) begin
                        cycles <= cycles + CNT_W'(1);
                    end
                    if (result_wr) begin
                        state      <= DONE;
                        gcd_result <= mem_wdata;
                        calc_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (req) begin
                        state     <= PENDING;
                        opa       <= gcd_a;
                        opb       <= gcd_b;
                        calc_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_mmio_port.sv
// Self-checking bench for gcd_mmio_port: directed job scenarios followed by randomized bus and request traffic,
// all compared against a job-level model of the port.
module tb_gcd_mmio_port;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        calc_start;
    logic [31:0] gcd_a;
    logic [31:0] gcd_b;
    logic [31:0] gcd_result;
    logic        calc_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_hit;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // Model: phase 0=idle, 1=job waiting, 2=firmware working, 3=result held.
    int          m_phase;
    bit          m_prev;
    logic [31:0] m_opa;
    logic [31:0] m_opb;
    logic [31:0] m_res;
    bit          m_done;
    longint      m_cycles;

    gcd_mmio_port #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .calc_start (calc_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_result (gcd_result),
        .calc_done  (calc_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_hit    (mem_hit)
    );

    always #5 clk = ~clk;

    function automatic bit in_window(input logic [31:0] addr);
        return (addr >= BASE) && (addr < BASE + 32'd64);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] addr, input bit re);
        int unsigned idx;
        if (!re || !in_window(addr)) return 32'd0;
        idx = (addr - BASE) / 4;
        case (idx)
            0:       return (m_phase == 0) ? 32'd0 : (32'd1 << (m_phase - 1));
            1:       return m_opa;
            2:       return m_opb;
            5:       return 32'(m_cycles);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit          req;
        bit          st;
        int unsigned idx;
        if (!rst_n) begin
            m_phase  = 0;
            m_prev   = 1'b0;
            m_opa    = 32'd0;
            m_opb    = 32'd0;
            m_res    = 32'd0;
            m_done   = 1'b0;
            m_cycles = 0;
        end else begin
            req    = calc_start && !m_prev;
            m_prev = calc_start;
            st     = mem_we && in_window(mem_addr);
            idx    = (mem_addr - BASE) / 4;
            case (m_phase)
                0: if (req) begin
                    m_phase = 1; m_opa = gcd_a; m_opb = gcd_b;
                end
                1: if (st && idx == 4 && mem_wdata[0]) begin
                    m_phase = 2; m_cycles = 0;
                end
                2: begin
                    if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
                    if (st && idx == 3) begin
                        m_phase = 3; m_res = mem_wdata; m_done = 1'b1;
                    end
                end
                default: if (req) begin
                    m_phase = 1; m_opa = gcd_a; m_opb = gcd_b; m_done = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("rdata", mem_rdata, model_rdata(mem_addr, mem_re));
            check_output("hit", 32'(mem_hit), 32'(in_window(mem_addr)));
            check_output("result", gcd_result, m_res);
            check_output("done", 32'(calc_done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [31:0] off, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = BASE + off;
        mem_wdata = data;
        tick();
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
    endtask

    task automatic load_check(input string name, input logic [31:0] off, input logic [31:0] exp);
        mem_re   = 1'b1;
        mem_addr = BASE + off;
        #1;
        check_output(name, mem_rdata, exp);
        mem_re   = 1'b0;
        mem_addr = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; calc_start = 1'b1; gcd_a = 32'd15; gcd_b = 32'd10;
        mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        tick();
        tick();
        check_en = 1'b1;
        load_check("rst_status", 32'h00, 32'd0);
        check_output("rst_result", gcd_result, 32'd0);
        check_output("rst_done", 32'(calc_done), 32'd0);

        // calc_start already high at release counts as a request.
        rst_n = 1'b1;
        tick();
        load_check("req_status", 32'h00, 32'd1);
        load_check("req_opa", 32'h04, 32'd15);
        load_check("req_opb", 32'h08, 32'd10);
        check_output("req_done", 32'(calc_done), 32'd0);
        check_output("req_result", gcd_result, 32'd0);

        store(32'h10, 32'd1);
        for (int i = 0; i < 6; i++) begin
            load_check("busy_status", 32'h00, 32'd2);
            tick();
        end
        store(32'h0C, 32'd5);
        load_check("done_status", 32'h00, 32'd4);
        load_check("done_cycles", 32'h14, 32'd7);
        check_output("done_result", gcd_result, 32'd5);
        check_output("done_done", 32'(calc_done), 32'd1);

        // Second job: a request arriving while BUSY must be dropped.
        calc_start = 1'b0; tick();
        calc_start = 1'b1; tick();
        load_check("job2_status", 32'h00, 32'd1);
        store(32'h10, 32'd1);
        calc_start = 1'b0; tick();
        gcd_a = 32'd21; gcd_b = 32'd14; calc_start = 1'b1; tick();
        load_check("busyreq_status", 32'h00, 32'd2);
        load_check("busyreq_opa", 32'h04, 32'd15);
        calc_start = 1'b0; tick();
        store(32'h0C, 32'd5);
        load_check("job2_done", 32'h00, 32'd4);
        calc_start = 1'b1; tick();
        load_check("job3_status", 32'h00, 32'd1);
        load_check("job3_opa", 32'h04, 32'd21);
        load_check("job3_opb", 32'h08, 32'd14);
        check_output("job3_result_hold", gcd_result, 32'd5);
        check_output("job3_done", 32'(calc_done), 32'd0);
        store(32'h10, 32'd1);
        store(32'h0C, 32'd7);
        check_output("job3_result", gcd_result, 32'd7);

        // Illegal accesses from IDLE.
        calc_start = 1'b0; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        load_check("idle_status", 32'h00, 32'd0);
        store(32'h0C, 32'd9);
        store(32'h10, 32'd1);
        store(32'h18, 32'hFFFF_FFFF);
        store(32'h10, 32'd0);
        load_check("illegal_status", 32'h00, 32'd0);
        load_check("illegal_opa", 32'h04, 32'd0);
        check_output("illegal_result", gcd_result, 32'd0);
        mem_re = 1'b1; mem_addr = BASE + 32'h40;
        #1;
        check_output("outside_rdata", mem_rdata, 32'd0);
        check_output("outside_hit", 32'(mem_hit), 32'd0);
        mem_re = 1'b0; mem_addr = 32'd0;

        // RESULT store and request edge in the same BUSY cycle.
        gcd_a = 32'd8; gcd_b = 32'd12; calc_start = 1'b1; tick();
        store(32'h10, 32'd1);
        calc_start = 1'b0; tick();
        calc_start = 1'b1;
        store(32'h0C, 32'd4);
        load_check("race_status", 32'h00, 32'd4);
        check_output("race_result", gcd_result, 32'd4);
        tick();
        load_check("race_status2", 32'h00, 32'd4);

        // Reset while BUSY discards the job.
        calc_start = 1'b0; tick();
        calc_start = 1'b1; tick();
        store(32'h10, 32'd1);
        tick(); tick();
        calc_start = 1'b0; rst_n = 1'b0; tick();
        rst_n = 1'b1;
        load_check("rbusy_status", 32'h00, 32'd0);
        load_check("rbusy_opa", 32'h04, 32'd0);
        load_check("rbusy_cycles", 32'h14, 32'd0);
        check_output("rbusy_done", 32'(calc_done), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) calc_start = ~calc_start;
            gcd_a     = $urandom;
            gcd_b     = $urandom;
            mem_wdata = $urandom;
            r         = int'($urandom_range(0, 9));
            mem_we    = (r < 7);
            case (r)
                0, 1, 2: mem_addr = BASE + 32'h10 + 32'($urandom_range(0, 3));
                3, 4:    mem_addr = BASE + 32'h0C;
                5:       mem_addr = BASE + 32'($urandom_range(0, 63));
                6:       mem_addr = BASE + 32'd64 + 32'($urandom_range(0, 255));
                default: mem_addr = ($urandom_range(0, 3) == 0) ? $urandom
                                                                : BASE + 32'($urandom_range(0, 63));
            endcase
            mem_re = ($urandom_range(0, 1) == 1);
            tick();
        end
        rst_n = 1'b1; mem_we = 1'b0; mem_re = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_mmio_port.md
Name: gcd_mmio_port

Overview:
- Memory-mapped bridge between the external GCD job interface (calc_start, gcd_a, gcd_b, gcd_result) and the rv32i_cpu load/store bus.
- Latches a job's operands when calc_start is requested and exposes them to firmware as registers.
- Firmware claims the job, computes, and stores the result; the block then holds gcd_result and raises calc_done.
- Sits inside rv32i_cpu, beside data memory, and is decoded by address window.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of the register window; 64-byte aligned.
- CNT_W, 32: width of the busy-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- calc_start  in  1  job request (level; edge-detected internally)
- gcd_a  in  32  operand A, sampled on the request edge
- gcd_b  in  32  operand B, sampled on the request edge
- gcd_result  out  32  last result written by firmware
- calc_done  out  1  high while the result is valid
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU store data
- mem_we  in  1  store strobe, one cycle per store
- mem_re  in  1  load strobe
- mem_rdata  out  32  load data (combinational)
- mem_hit  out  1  mem_addr lies in [BASE_ADDR, BASE_ADDR+0x3F]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n: all state is cleared on the first rising clk edge with rst_n=0.
- Reset values: state=IDLE, start_q=0, opa=opb=0, gcd_result=0, calc_done=0, cycles=0. mem_rdata=0 when no load hits.
- Request detection: req = calc_start & ~start_q, where start_q is calc_start registered each cycle. Because start_q resets to 0, a calc_start already high when rst_n is released counts as a request on the first active edge.
- Register map (word offsets, full 32-bit access only; mem_addr[1:0] is ignored):
  - 0x00 STATUS (RO): bit0=PENDING, bit1=BUSY, bit2=DONE; bits 31:3 read 0.
  - 0x04 OPA (RO)
  - 0x08 OPB (RO)
  - 0x0C RESULT (WO): reads 0.
  - 0x10 CTRL (WO): bit0=CLAIM; reads 0.
  - 0x14 CYCLES (RO)
  - Other offsets in the window read 0; writes to them are ignored.
- Loads: mem_rdata is combinational from mem_addr when mem_re & mem_hit, otherwise 0. A read in the same cycle as a register update returns the pre-edge value.
- State machine (one-hot STATUS encoding; IDLE reads STATUS=0):
  - IDLE --req--> PENDING: on that edge, opa<=gcd_a and opb<=gcd_b.
  - PENDING --store of CTRL with bit0=1--> BUSY: cycles<=0.
  - BUSY: cycles increments every cycle and saturates at all-ones (CNT_W bits).
  - BUSY --store of RESULT--> DONE: gcd_result<=mem_wdata, calc_done<=1.
  - DONE --req--> PENDING: operands are re-latched; calc_done<=0; gcd_result holds its old value until the next RESULT store.
- Ignored events (no state change):
  - req while in PENDING or BUSY; the request is not queued.
  - CLAIM outside PENDING.
  - RESULT store outside BUSY.
  - CTRL store with bit0=0.
- Simultaneous events:
  - req and a RESULT store in the same BUSY cycle: the store wins, state goes to DONE, and the req is dropped.
  - req and a CLAIM store in the same PENDING cycle: the claim wins.
- Stores outside the window (mem_hit=0) have no effect.
- Reset mid-operation from any state: return to IDLE with all reset values, and discard the pending job.

Test Plan:
- Reset release with calc_start=1 and a=15, b=10: on the next edge STATUS=1, OPA=15, OPB=10, calc_done=0, gcd_result=0.
- Store CTRL=1, wait 7 cycles, store RESULT=5: STATUS reads 2 during the wait. Afterwards STATUS=4, gcd_result=5, calc_done=1, and CYCLES equals the number of cycles spent in BUSY (7 under the bench's cycle counting).
- In BUSY, toggle calc_start with a=21, b=14: STATUS stays 2 and OPA stays 15. After RESULT=5, a fresh edge gives STATUS=1, OPA=21, and gcd_result still 5 until a RESULT store of 7.
- Illegal accesses: a RESULT store in IDLE, CLAIM in IDLE, a store to offset 0x18, and a load from BASE_ADDR+0x40. Required: no state change, and the load returns mem_rdata=0 with mem_hit=0.
- Same-cycle RESULT store and calc_start edge in BUSY: DONE is reached and PENDING is not entered.
- Assert rst_n=0 for one cycle while in BUSY: the next cycle shows STATUS=0, OPA=0, CYCLES=0, calc_done=0.
